textmode_render: RTL and testbench

//  Text-mode pixel generator fed directly by the 480p display timing block (sx/sy/de/hsync/vsync/frame).

---
 rtl/textmode_pkg.sv | 22 ++
 rtl/textmode_delay.sv | 27 ++
 rtl/textmode_render.sv | 143 ++++++++++++++
 tb/tb_textmode_render.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/textmode_pkg.sv
// Shared types and constants for the text-mode renderer: CGA palette, attribute
// byte layout and pipeline depth.
package textmode_pkg;

    typedef logic [11:0] rgb12_t;

    localparam int LATENCY = 4;

    localparam int ATTR_FG_LSB = 0;
    localparam int ATTR_FG_MSB = 3;
    localparam int ATTR_BG_LSB = 4;
    localparam int ATTR_BG_MSB = 6;
    localparam int ATTR_BLINK  = 7;

    localparam rgb12_t PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

endpackage

// File: rtl/textmode_delay.sv
// N-stage register delay line with a synchronous active-low reset to a
// configurable value; keeps side-band signals aligned with the render pipe.
module textmode_delay #(
    parameter int             W       = 1,
    parameter int             N       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_pipe [N];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N; i++) r_pipe[i] <= RST_VAL;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[N-1];

endmodule

// File: rtl/textmode_render.sv
// Text-mode pixel generator: screen position -> text RAM -> font ROM -> palette,
// four register stages with syncs and data enable realigned to the RGB output.
module textmode_render
    import textmode_pkg::*;
#(
    parameter int   CORDW        = 16,
    parameter int   COLS         = 80,
    parameter int   ROWS         = 30,
    parameter int   GLYPH_W      = 8,
    parameter int   GLYPH_H      = 16,
    parameter int   ADDRW        = 12,
    parameter int   BLINK_FRAMES = 32,
    parameter logic H_POL        = 1'b0,
    parameter logic V_POL        = 1'b0
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic                    de,
    input  logic                    hsync,
    input  logic                    vsync,
    input  logic                    frame,
    output logic [ADDRW-1:0]        text_addr,
    input  logic [15:0]             text_data,
    output logic [11:0]             font_addr,
    input  logic [7:0]              font_data,
    input  logic                    cursor_en,
    input  logic [6:0]              cursor_col,
    input  logic [4:0]              cursor_row,
    output rgb12_t                  rgb,
    output logic                    hsync_o,
    output logic                    vsync_o,
    output logic                    de_o
);

    localparam int GW_SH = $clog2(GLYPH_W);
    localparam int GH_SH = $clog2(GLYPH_H);
    localparam int FCW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Constant multiply by COLS expressed as a sum of shifted rows.
    function automatic logic [ADDRW-1:0] mul_cols(input logic [ADDRW-1:0] row);
        logic [ADDRW-1:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++)
            if (((COLS >> i) & 1) != 0) acc = acc + (row << i);
        return acc;
    endfunction

    logic [CORDW-1:0] w_col, w_row;
    logic [GH_SH-1:0] w_grow, w_grow_p1;
    logic [GW_SH-1:0] w_sxlo, w_sxlo_p2;
    logic             w_neg, w_neg_p1, w_vis, w_hit, w_vis_p3, w_hit_p3;
    logic [7:0]       r_attr_p2, r_attr_p3;
    logic             r_pix_p3;
    logic [FCW-1:0]   r_frame_cnt;
    logic             r_blink_phase;
    logic [3:0]       w_sel, w_fg, w_bg;

    assign w_neg  = sx[CORDW-1] | sy[CORDW-1];
    assign w_col  = sx >>> GW_SH;
    assign w_row  = sy >>> GH_SH;
    assign w_grow = sy[GH_SH-1:0];
    assign w_sxlo = sx[GW_SH-1:0];
    assign w_vis  = de && !w_neg && (int'(sx) < COLS*GLYPH_W) && (int'(sy) < ROWS*GLYPH_H);
    assign w_hit  = cursor_en && w_vis
                 && (int'(cursor_col) < COLS) && (int'(cursor_row) < ROWS)
                 && (w_col == CORDW'(cursor_col)) && (w_row == CORDW'(cursor_row))
                 && (int'(w_grow) >= GLYPH_H - 2);

    // S1: cell address; held during blanking so the RAM never sees a bogus read
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n)  text_addr <= '0;
        else if (!w_neg) text_addr <= mul_cols(ADDRW'(w_row)) + ADDRW'(w_col);
    end

    textmode_delay #(.W(1), .N(1), .RST_VAL(1'b1)) u_dly_neg (
        .i_clk(clk_pix), .i_rst_n(rst_pix_n), .i_d(w_neg), .o_q(w_neg_p1));
    textmode_delay #(.W(GH_SH), .N(1)) u_dly_grow (
        .i_clk(clk_pix), .i_rst_n(rst_pix_n), .i_d(w_grow), .o_q(w_grow_p1));

    // S2: char code available; form glyph row address and capture attribute
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            font_addr <= '0;
            r_attr_p2 <= '0;
        end else begin
            r_attr_p2 <= text_data[15:8];
            if (!w_neg_p1)
                font_addr <= 12'(int'(text_data[7:0]) * GLYPH_H + int'(w_grow_p1));
        end
    end

    textmode_delay #(.W(GW_SH), .N(LATENCY-2)) u_dly_sxlo (
        .i_clk(clk_pix), .i_rst_n(rst_pix_n), .i_d(w_sxlo), .o_q(w_sxlo_p2));

    // S3: glyph row available; bit 7 is the leftmost pixel
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            r_pix_p3  <= 1'b0;
            r_attr_p3 <= '0;
        end else begin
            r_pix_p3  <= font_data[~w_sxlo_p2];
            r_attr_p3 <= r_attr_p2;
        end
    end

    textmode_delay #(.W(2), .N(LATENCY-1)) u_dly_vis (
        .i_clk(clk_pix), .i_rst_n(rst_pix_n), .i_d({w_vis, w_hit}), .o_q({w_vis_p3, w_hit_p3}));
    textmode_delay #(.W(3), .N(LATENCY), .RST_VAL({1'b0, ~H_POL, ~V_POL})) u_dly_sync (
        .i_clk(clk_pix), .i_rst_n(rst_pix_n), .i_d({de, hsync, vsync}), .o_q({de_o, hsync_o, vsync_o}));

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (frame) begin
            if (r_frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_fg = r_attr_p3[ATTR_FG_MSB:ATTR_FG_LSB];
    assign w_bg = {1'b0, r_attr_p3[ATTR_BG_MSB:ATTR_BG_LSB]};

    // Visible cursor overrides blink-hidden cells, which override the glyph
    always_comb begin
        w_sel = r_pix_p3 ? w_fg : w_bg;
        if (w_hit_p3 && r_blink_phase)                    w_sel = w_fg;
        else if (r_attr_p3[ATTR_BLINK] && !r_blink_phase) w_sel = w_bg;
    end

    // S4: registered colour
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) rgb <= '0;
        else            rgb <= w_vis_p3 ? PALETTE[w_sel] : '0;
    end

endmodule

// File: tb/tb_textmode_render.sv
// Randomised scoreboard bench for textmode_render with a cell/glyph/palette
// reference model and combinational text RAM / font ROM models.
module tb_textmode_render;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_pix_n;
    logic signed [15:0] sx, sy;
    logic               de, hsync, vsync, frame;
    logic [11:0]        text_addr, font_addr, rgb;
    logic [15:0]        text_data;
    logic [7:0]         font_data;
    logic               cursor_en;
    logic [6:0]         cursor_col;
    logic [4:0]         cursor_row;
    logic               hsync_o, vsync_o, de_o;

    logic [15:0] tram [4096];
    logic [7:0]  from [4096];
    assign text_data = tram[text_addr];
    assign font_data = from[font_addr];

    textmode_render dut (
        .clk_pix(clk), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy), .de(de),
        .hsync(hsync), .vsync(vsync), .frame(frame),
        .text_addr(text_addr), .text_data(text_data),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o));

    typedef struct { int due; logic [11:0] rgb; logic de; logic hs; logic vs; } px_t;
    typedef struct { int due; logic [11:0] val; } ad_t;
    px_t px_q[$];
    ad_t ta_q[$];
    ad_t fa_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          npulse = 0;
    logic [11:0] last_ta = '0, last_fa = '0;
    logic        cen_n = 1'b0;
    int          ccol_n = 0, crow_n = 0;

    function automatic logic [11:0] cga(input int idx);
        case (idx)
            0: return 12'h000;  1: return 12'h00A;  2: return 12'h0A0;  3: return 12'h0AA;
            4: return 12'hA00;  5: return 12'hA0A;  6: return 12'hA50;  7: return 12'hAAA;
            8: return 12'h555;  9: return 12'h55F; 10: return 12'h5F5; 11: return 12'h5FF;
           12: return 12'hF55; 13: return 12'hF5F; 14: return 12'hFF5; default: return 12'hFFF;
        endcase
    endfunction

    // Expected colour straight from the display rules, using the current memories.
    function automatic logic [11:0] ref_rgb(input int x, input int y, input logic d, input logic phase);
        int col, row, code, attr, fg, bg, sel;
        logic [7:0] g;
        logic pix, hit;
        if (!(d && x >= 0 && x < 640 && y >= 0 && y < 480)) return 12'h000;
        col  = x / 8;
        row  = y / 16;
        code = int'(tram[row*80 + col][7:0]);
        attr = int'(tram[row*80 + col][15:8]);
        g    = from[code*16 + y%16];
        pix  = g[7 - x%8];
        fg   = attr % 16;
        bg   = (attr / 16) % 8;
        hit  = cen_n && ccol_n < 80 && crow_n < 30 && col == ccol_n && row == crow_n && (y%16) >= 14;
        if (hit && phase)                 sel = fg;
        else if (attr >= 128 && !phase)   sel = bg;
        else                              sel = pix ? fg : bg;
        return cga(sel);
    endfunction

    task automatic issue(input int x, input int y, input logic d, input logic h,
                         input logic v, input logic f, input logic r);
        logic phase;
        @(negedge clk);
        rst_pix_n  = r;
        sx = 16'(x); sy = 16'(y);
        de = d; hsync = h; vsync = v; frame = f;
        cursor_en  = cen_n;
        cursor_col = 7'(ccol_n);
        cursor_row = 5'(crow_n);
        if (!r) begin
            foreach (px_q[i]) if (px_q[i].due > cyc) px_q[i] = '{px_q[i].due, 12'h000, 1'b0, 1'b1, 1'b1};
            foreach (fa_q[i]) if (fa_q[i].due > cyc) fa_q[i].val = '0;
            ta_q.push_back('{cyc + 1, 12'h000});
            fa_q.push_back('{cyc + 2, 12'h000});
            px_q.push_back('{cyc + 4, 12'h000, 1'b0, 1'b1, 1'b1});
            npulse = 0; last_ta = '0; last_fa = '0;
        end else begin
            if (f) npulse++;
            phase = ((npulse / 32) % 2) == 0;
            if (x >= 0 && y >= 0) begin
                last_ta = 12'((y/16)*80 + x/8);
                last_fa = 12'(int'(tram[last_ta][7:0])*16 + y%16);
            end
            ta_q.push_back('{cyc + 1, last_ta});
            fa_q.push_back('{cyc + 2, last_fa});
            px_q.push_back('{cyc + 4, ref_rgb(x, y, d, phase), d, h, v});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(-50, -5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    // Monitor: pop whatever is due this cycle and compare.
    initial begin
        px_t p;
        ad_t a;
        forever begin
            @(negedge clk);
            while (ta_q.size() > 0 && ta_q[0].due <= cyc) begin
                a = ta_q.pop_front();
                checks++;
                if (text_addr !== a.val) begin
                    errors++;
                    $display("FAIL text_addr cyc=%0d got=%h exp=%h", cyc, text_addr, a.val);
                end
            end
            while (fa_q.size() > 0 && fa_q[0].due <= cyc) begin
                a = fa_q.pop_front();
                checks++;
                if (font_addr !== a.val) begin
                    errors++;
                    $display("FAIL font_addr cyc=%0d got=%h exp=%h", cyc, font_addr, a.val);
                end
            end
            while (px_q.size() > 0 && px_q[0].due <= cyc) begin
                p = px_q.pop_front();
                checks++;
                if (rgb !== p.rgb || de_o !== p.de || hsync_o !== p.hs || vsync_o !== p.vs) begin
                    errors++;
                    $display("FAIL pixel cyc=%0d got rgb=%h de=%b hs=%b vs=%b exp rgb=%h de=%b hs=%b vs=%b",
                             cyc, rgb, de_o, hsync_o, vsync_o, p.rgb, p.de, p.hs, p.vs);
                end
            end
        end
    end

    initial begin
        int x, y;
        rst_pix_n = 1'b0; sx = '0; sy = '0; de = 1'b0; hsync = 1'b1; vsync = 1'b1; frame = 1'b0;
        cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
        for (int i = 0; i < 4096; i++) begin
            tram[i] = 16'($urandom);
            from[i] = 8'($urandom);
        end
        tram[0]       = 16'h1F41;
        from[12'h410] = 8'h80;
        tram[165]     = 16'h2C33;

        for (int i = 0; i < 5; i++) issue(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // First cell, first two pixels; then screen corner and blanking hold
        issue(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        issue(1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        issue(639, 479, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        issue(-1, 479, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(-1, 479, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Cursor at column 5, row 2: underline rows vs. normal glyph row
        cen_n = 1'b1; ccol_n = 5; crow_n = 2;
        for (int k = 0; k < 8; k++) issue(40 + k, 46, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) issue(40 + k, 45, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) issue(40 + k, 47, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

        for (int n = 0; n < 1500; n++) begin
            if (n % 50 == 0) begin
                cen_n  = 1'($urandom);
                ccol_n = $urandom_range(0, 90);
                crow_n = $urandom_range(0, 33);
            end
            if ($urandom_range(0, 9) < 3) begin
                x = ccol_n*8 + $urandom_range(0, 7);
                y = crow_n*16 + $urandom_range(12, 15);
            end else begin
                x = $urandom_range(0, 719) - 40;
                y = $urandom_range(0, 509) - 10;
            end
            issue(x, y, ($urandom_range(0, 9) < 8), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
        end

        // Blinking cell across 66 frame pulses
        cen_n = 1'b0;
        idle(6);
        tram[250] = 16'h8F55;
        from[12'h555] = 8'hA5;
        for (int p = 0; p < 66; p++) begin
            idle(3);
            issue(-50, -5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            for (int k = 0; k < 8; k++) issue(80 + k, 53, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        end

        // Reset in the middle of visible traffic, with frame pulses ignored
        for (int i = 0; i < 10; i++)
            issue($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 200; n++)
            issue($urandom_range(0, 699) - 30, $urandom_range(0, 499) - 10,
                  1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);

        idle(8);
        for (int k = 0; k < 20 && (px_q.size() + ta_q.size() + fa_q.size()) > 0; k++) @(negedge clk);
        checks++;
        if ((px_q.size() + ta_q.size() + fa_q.size()) != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", px_q.size() + ta_q.size() + fa_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
